// File: rtl/snake_direction_controller.sv
// Turns debounced button levels into a queue of snake heading commands.
// The controller accepts only perpendicular turns. It releases one command on
// each game tick. Game over halts it until reset.
//
// state  | meaning
// S_IDLE | waiting for the first accepted press; ticks ignored
// S_RUN  | queue accepted presses, step and pop one command per tick
// S_HALT | game over: queue flushed, inputs ignored until reset
module snake_direction_controller #(
   parameter int unsigned c_QUEUE_DEPTH = 4,
   parameter logic [1:0]  c_INIT_DIR    = 2'b11
) (
   input  logic                             i_Clk,
   input  logic                             i_Reset,
   input  logic [3:0]                       i_Buttons,
   input  logic                             i_Tick,
   input  logic                             i_GameOver,
   output logic [1:0]                       o_Dir,
   output logic                             o_Step,
   output logic                             o_Running,
   output logic [$clog2(c_QUEUE_DEPTH):0]   o_Count,
   output logic                             o_Overflow
);

   localparam int unsigned PW = $clog2(c_QUEUE_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(c_QUEUE_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t          state, state_nxt;
   logic [3:0]      prev_btn;
   logic [3:0]      press;
   logic            cand_valid;
   logic [1:0]      cand;
   logic [1:0]      ref_dir;
   logic            accept;
   logic            push, pop, flush, step_nxt, ovf_set;
   logic [1:0]      fifo_mem [c_QUEUE_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;

   // Rising-edge press detect with fixed priority, and the reversal/duplicate filter.
   // The filter compares against the last queued heading, so a burst of presses
   // is judged as a path rather than against the current heading alone.
   always_comb begin
      press      = i_Buttons & ~prev_btn;
      cand_valid = |press;
      cand       = 2'b00;
      if (press[0])      cand = 2'b00;
      else if (press[1]) cand = 2'b01;
      else if (press[2]) cand = 2'b10;
      else if (press[3]) cand = 2'b11;
      ref_dir = (o_Count != '0) ? fifo_mem[wr_ptr - PW'(1)] : o_Dir;
      accept  = cand_valid && (cand[1] != ref_dir[1]);
   end

   // State register.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state and queue control. Game over overrides push and tick.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      step_nxt  = 1'b0;
      ovf_set   = 1'b0;
      if (i_GameOver) begin
         state_nxt = S_HALT;
         flush     = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  push      = 1'b1;
                  state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               step_nxt = i_Tick;
               pop      = i_Tick && (o_Count != '0);
               if (accept) begin
                  // A pop in the same cycle frees a slot, so a full queue still takes the press.
                  if ((o_Count != FULL) || pop) push    = 1'b1;
                  else                          ovf_set = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Queue storage; contents are don't-care while the count says empty.
   always_ff @(posedge i_Clk) begin
      if (push && !flush) fifo_mem[wr_ptr] <= cand;
   end

   // Heading, step strobe, pointers, occupancy and sticky overflow.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         prev_btn   <= 4'hF;
         o_Dir      <= c_INIT_DIR;
         o_Step     <= 1'b0;
         o_Count    <= '0;
         o_Overflow <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         prev_btn <= i_Buttons;
         o_Step   <= step_nxt;
         if (ovf_set) o_Overflow <= 1'b1;
         if (flush) begin
            o_Count <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
               o_Dir  <= fifo_mem[rd_ptr];
               rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
               2'b10:   o_Count <= o_Count + CW'(1);
               2'b01:   o_Count <= o_Count - CW'(1);
               default: ;
            endcase
         end
      end
   end

   assign o_Running = (state == S_RUN);

endmodule

// File: tb/tb_snake_direction_controller.sv
// Bench for snake_direction_controller: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_snake_direction_controller;

   localparam int unsigned D = 4;
   localparam logic [1:0] INIT_DIR = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn = 4'h0;
   logic       tick = 1'b0;
   logic       go = 1'b0;
   logic [1:0] dir;
   logic       step;
   logic       running;
   logic [2:0] count;
   logic       ovf;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [3:0] m_prev;
   logic [1:0] m_dir;
   logic       m_step;
   logic       m_run;
   logic       m_halt;
   logic       m_ovf;
   logic [1:0] m_q[$];

   snake_direction_controller #(.c_QUEUE_DEPTH(D), .c_INIT_DIR(INIT_DIR)) dut (
      .i_Clk      (clk),
      .i_Reset    (rst),
      .i_Buttons  (btn),
      .i_Tick     (tick),
      .i_GameOver (go),
      .o_Dir      (dir),
      .o_Step     (step),
      .o_Running  (running),
      .o_Count    (count),
      .o_Overflow (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock of the game rules, written from the behaviour description.
   task automatic model_step(input logic [3:0] b, input logic t, input logic g, input logic r);
      logic [3:0] pr;
      logic [1:0] c;
      logic [1:0] refd;
      bit         valid;
      bit         acc;
      bit         full;
      if (r) begin
         m_dir = INIT_DIR; m_step = 0; m_run = 0; m_halt = 0; m_ovf = 0;
         m_prev = 4'hF; m_q.delete();
         return;
      end
      pr = b & ~m_prev;
      m_prev = b;
      m_step = 0;
      if (g) begin
         m_halt = 1; m_run = 0; m_q.delete();
         return;
      end
      if (m_halt) return;
      valid = (pr != 0);
      c = 0;
      for (int i = 3; i >= 0; i--) if (pr[i]) c = 2'(i);
      refd = (m_q.size() > 0) ? m_q[$] : m_dir;
      acc = valid && (c[1] != refd[1]);
      if (!m_run) begin
         if (acc) begin
            m_q.push_back(c);
            m_run = 1;
         end
         return;
      end
      full = (m_q.size() == D);
      m_step = t;
      if (t && m_q.size() > 0) begin
         m_dir = m_q.pop_front();
         full = 0;
      end
      if (acc) begin
         if (!full) m_q.push_back(c);
         else       m_ovf = 1;
      end
   endtask

   task automatic cycle(input logic [3:0] b, input logic t, input logic g, input logic r);
      btn = b; tick = t; go = g; rst = r;
      @(posedge clk);
      #1;
      model_step(b, t, g, r);
      chk("dir", dir, m_dir);
      chk("step", step, m_step);
      chk("running", running, (m_run && !m_halt) ? 1 : 0);
      chk("count", count, m_q.size());
      chk("overflow", ovf, m_ovf);
   endtask

   task automatic do_reset();
      cycle(4'h0, 0, 0, 1);
      cycle(4'h0, 0, 0, 0);
   endtask

   task automatic press(input logic [3:0] b);
      cycle(b, 0, 0, 0);
      cycle(4'h0, 0, 0, 0);
   endtask

   initial begin
      logic [3:0] rb;
      // 1: button held through reset gives no press; ticks ignored in idle
      cycle(4'h1, 0, 0, 1);
      cycle(4'h1, 0, 0, 1);
      repeat (3) cycle(4'h1, 1, 0, 0);
      chk("t1_running", running, 0);
      chk("t1_step", step, 0);
      chk("t1_dir", dir, 3);
      chk("t1_count", count, 0);

      // 2: first press starts the game, tick applies it with latency 1
      cycle(4'h0, 0, 0, 0);
      cycle(4'h1, 0, 0, 0);
      chk("t2_running", running, 1);
      chk("t2_count", count, 1);
      cycle(4'h0, 1, 0, 0);
      chk("t2_dir", dir, 0);
      chk("t2_step", step, 1);
      chk("t2_count0", count, 0);

      // 3: same-axis presses dropped, filter follows the queue tail
      do_reset();
      press(4'h4);
      press(4'h8);
      chk("t3_nopush", count, 0);
      press(4'h1);
      press(4'h2);
      chk("t3_count", count, 1);

      // 4: fill to depth, overflow on the fifth, drain in order
      do_reset();
      press(4'h1); press(4'h4); press(4'h2); press(4'h8);
      cycle(4'h1, 0, 0, 0);
      chk("t4_ovf", ovf, 1);
      chk("t4_count", count, 4);
      cycle(4'h0, 1, 0, 0); chk("t4_d0", dir, 0);
      cycle(4'h0, 1, 0, 0); chk("t4_d1", dir, 2);
      cycle(4'h0, 1, 0, 0); chk("t4_d2", dir, 1);
      cycle(4'h0, 1, 0, 0); chk("t4_d3", dir, 3);
      chk("t4_empty", count, 0);

      // 5: push and pop together while full
      do_reset();
      press(4'h1); press(4'h4); press(4'h2); press(4'h8);
      cycle(4'h1, 1, 0, 0);
      chk("t5_count", count, 4);
      chk("t5_ovf", ovf, 0);
      chk("t5_dir", dir, 0);
      chk("t5_step", step, 1);

      // 6: game over flushes and freezes everything until reset
      do_reset();
      press(4'h1); press(4'h4);
      cycle(4'h0, 1, 1, 0);
      chk("t6_count", count, 0);
      chk("t6_step", step, 0);
      chk("t6_dir", dir, 3);
      cycle(4'h2, 1, 0, 0);
      cycle(4'h0, 1, 0, 0);
      cycle(4'h4, 1, 0, 0);
      chk("t6_frozen_dir", dir, 3);
      chk("t6_frozen_cnt", count, 0);
      chk("t6_frozen_run", running, 0);

      // randomized traffic
      do_reset();
      rb = 4'h0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 2) == 0) rb = 4'($urandom_range(0, 15));
         cycle(rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0),
               ($urandom_range(0, 199) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
